// File: rtl/countdown_display.sv
// Two-digit BCD countdown consumer: filters the digit bus, drives two active-low
// seven-segment displays and raises a blinking alarm when a running count reaches 00.
module countdown_display #(
  parameter int TICK_DIV     = 25000000,
  parameter int ALARM_BLINKS = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_digit1,
  input  logic [3:0] i_digit2,
  input  logic       i_ack,
  output logic [6:0] o_hex0,
  output logic [6:0] o_hex1,
  output logic       o_alarm,
  output logic       o_expired
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(2 * ALARM_BLINKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * ALARM_BLINKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_ALARM    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      4'd10:   seg_decode = 7'b1111111;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  logic [7:0]    r_s1;
  logic [7:0]    r_s2;
  logic [7:0]    r_held;
  logic          r_ack_meta;
  logic          r_ack_sync;
  logic          r_ack_prev;
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink;
  logic          r_phase;

  state_t        w_state_next;
  logic [PW-1:0] w_presc_next;
  logic [BW-1:0] w_blink_next;
  logic          w_phase_next;
  logic          w_show_blank;
  logic          w_blank;
  logic          w_zero;
  logic          w_run;
  logic          w_tick;
  logic          w_ack_rise;

  // Two-sample stability filter on the digit bus
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 8'hAA;
      r_s2   <= 8'hAA;
      r_held <= 8'hAA;
    end else begin
      r_s1 <= {i_digit2, i_digit1};
      r_s2 <= r_s1;
      if (r_s1 == r_s2) begin
        r_held <= r_s2;
      end
    end
  end

  // Acknowledge synchronizer with edge-detect history
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack_meta <= 1'b0;
      r_ack_sync <= 1'b0;
      r_ack_prev <= 1'b0;
    end else begin
      r_ack_meta <= i_ack;
      r_ack_sync <= r_ack_meta;
      r_ack_prev <= r_ack_sync;
    end
  end

  assign w_blank    = (r_held[3:0] > 4'd9) || (r_held[7:4] > 4'd9);
  assign w_zero     = (r_held == 8'h00);
  assign w_run      = !w_blank && !w_zero;
  assign w_tick     = (r_state == ST_ALARM) && (r_presc == PRESC_LAST);
  assign w_ack_rise = r_ack_sync && !r_ack_prev;

  // Next-state and alarm timer logic; held class outranks ack, ack outranks timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_run) begin
          w_state_next = ST_COUNTING;
        end else if (w_zero) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_COUNTING: begin
        if (w_zero) begin
          w_state_next = ST_ALARM;
        end else if (w_blank) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_COUNTING;
        end
      end
      ST_ALARM: begin
        if (w_run) begin
          w_state_next = ST_COUNTING;
        end else if (w_blank) begin
          w_state_next = ST_IDLE;
        end else if (w_ack_rise) begin
          w_state_next = ST_DONE;
        end else if (w_tick && (r_blink == BLINK_LAST)) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_ALARM;
        end
      end
      ST_DONE: begin
        if (w_run) begin
          w_state_next = ST_COUNTING;
        end else if (w_blank) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Timers only advance while staying in ALARM; entry and any other state zero them
    if ((r_state == ST_ALARM) && (w_state_next == ST_ALARM)) begin
      w_presc_next = w_tick ? {PW{1'b0}} : (r_presc + PW'(1));
      w_blink_next = w_tick ? (r_blink + BW'(1)) : r_blink;
      w_phase_next = r_phase ^ w_tick;
    end else begin
      w_presc_next = {PW{1'b0}};
      w_blink_next = {BW{1'b0}};
      w_phase_next = 1'b0;
    end

    w_show_blank = (w_state_next == ST_ALARM) && w_phase_next;
  end

  // State, timers and registered display/alarm outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_presc   <= {PW{1'b0}};
      r_blink   <= {BW{1'b0}};
      r_phase   <= 1'b0;
      o_hex0    <= 7'b1111111;
      o_hex1    <= 7'b1111111;
      o_alarm   <= 1'b0;
      o_expired <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_blink   <= w_blink_next;
      r_phase   <= w_phase_next;
      o_hex0    <= w_show_blank ? 7'b1111111 : seg_decode(r_held[3:0]);
      o_hex1    <= w_show_blank ? 7'b1111111 : seg_decode(r_held[7:4]);
      o_alarm   <= (w_state_next == ST_ALARM);
      o_expired <= (w_state_next == ST_ALARM) || (w_state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// Scoreboard bench for countdown_display: a time-based reference model queues the
// expected outputs for every clock, and a negedge monitor pops and compares them.
module tb_countdown_display;

  localparam int TD = 4;
  localparam int AB = 2;
  localparam logic [6:0] SEG [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] d1 = 4'd10;
  logic [3:0] d2 = 4'd10;
  logic       ack = 1'b0;
  logic [6:0] o_hex0;
  logic [6:0] o_hex1;
  logic       o_alarm;
  logic       o_expired;

  always #5 clk = ~clk;

  countdown_display #(.TICK_DIV(TD), .ALARM_BLINKS(AB)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_digit1  (d1),
    .i_digit2  (d2),
    .i_ack     (ack),
    .o_hex0    (o_hex0),
    .o_hex1    (o_hex1),
    .o_alarm   (o_alarm),
    .o_expired (o_expired)
  );

  typedef struct packed {
    logic [6:0] h1;
    logic [6:0] h0;
    logic       al;
    logic       ex;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: mode 0 idle, 1 counting, 2 alarm, 3 done; m_t = cycles spent in alarm
  int         m_mode;
  int         m_t;
  logic [7:0] m_held;
  logic [7:0] m_p1;
  logic [7:0] m_p2;
  logic       m_a1;
  logic       m_a2;
  logic       m_a3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_t    = 0;
    m_held = 8'hAA;
    m_p1   = 8'hAA;
    m_p2   = 8'hAA;
    m_a1   = 1'b0;
    m_a2   = 1'b0;
    m_a3   = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] lo;
    logic [3:0] hi;
    bit         blank;
    bit         zero;
    bit         run;
    bit         rise;
    bit         dark;
    exp_t       e;
    lo    = m_held[3:0];
    hi    = m_held[7:4];
    blank = (lo > 4'd9) || (hi > 4'd9);
    zero  = (m_held == 8'h00);
    run   = !blank && !zero;
    rise  = m_a2 && !m_a3;
    case (m_mode)
      0: if (run) m_mode = 1; else if (zero) m_mode = 3;
      1: if (zero) begin m_mode = 2; m_t = 0; end else if (blank) m_mode = 0;
      2: begin
        if (run) m_mode = 1;
        else if (blank) m_mode = 0;
        else if (rise) m_mode = 3;
        else begin
          m_t++;
          if (m_t >= 2 * AB * TD) m_mode = 3;
        end
      end
      default: if (run) m_mode = 1; else if (blank) m_mode = 0;
    endcase
    dark = (m_mode == 2) && (((m_t / TD) % 2) == 1);
    e.h0 = dark ? 7'b1111111 : SEG[lo];
    e.h1 = dark ? 7'b1111111 : SEG[hi];
    e.al = (m_mode == 2);
    e.ex = (m_mode >= 2);
    q.push_back(e);
    if (m_p1 == m_p2) m_held = m_p1;
    m_p2 = m_p1;
    m_p1 = {d2, d1};
    m_a3 = m_a2;
    m_a2 = m_a1;
    m_a1 = ack;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("hex0", {25'd0, o_hex0}, {25'd0, e.h0});
      check("hex1", {25'd0, o_hex1}, {25'd0, e.h1});
      check("alarm", {31'd0, o_alarm}, {31'd0, e.al});
      check("expired", {31'd0, o_expired}, {31'd0, e.ex});
    end
  end

  task automatic cyc(input logic [3:0] t, input logic [3:0] o, input logic a);
    d2  = t;
    d1  = o;
    ack = a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hold(input logic [3:0] t, input logic [3:0] o, input logic a, input int n);
    for (int i = 0; i < n; i++) cyc(t, o, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_hex0", {25'd0, o_hex0}, 32'h7F);
    check("rst_hex1", {25'd0, o_hex1}, 32'h7F);
    check("rst_alarm", {31'd0, o_alarm}, 32'd0);
    check("rst_expired", {31'd0, o_expired}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Decode and digit sweep
    hold(4'd2, 4'd5, 1'b0, 6);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] v;
      logic [3:0] w;
      v = (i < 10) ? 4'(i) : ((i == 10) ? 4'd10 : 4'd12);
      w = (i < 6) ? 4'(i + 4) : 4'(i - 6);
      hold(w, v, 1'b0, 4);
      hold(v, w, 1'b0, 4);
    end

    // Natural expiry
    do_reset();
    hold(4'd0, 4'd1, 1'b0, 6);
    hold(4'd0, 4'd0, 1'b0, 24);

    // Ack pulse in the middle of the alarm
    hold(4'd0, 4'd1, 1'b0, 6);
    hold(4'd0, 4'd0, 1'b0, 9);
    cyc(4'd0, 4'd0, 1'b1);
    hold(4'd0, 4'd0, 1'b0, 10);

    // Ack held high across alarm entry
    hold(4'd0, 4'd1, 1'b1, 6);
    hold(4'd0, 4'd0, 1'b1, 12);
    hold(4'd0, 4'd0, 1'b0, 14);

    // Single-cycle glitch, reload during alarm, blank return to idle
    hold(4'd4, 4'd7, 1'b0, 6);
    cyc(4'd4, 4'd3, 1'b0);
    hold(4'd4, 4'd7, 1'b0, 5);
    hold(4'd0, 4'd1, 1'b0, 5);
    hold(4'd0, 4'd0, 1'b0, 7);
    hold(4'd3, 4'd0, 1'b0, 6);
    hold(4'd10, 4'd10, 1'b0, 5);

    // Reset in the middle of an alarm, then 00 again
    hold(4'd0, 4'd1, 1'b0, 5);
    hold(4'd0, 4'd0, 1'b0, 8);
    do_reset();
    hold(4'd0, 4'd0, 1'b0, 8);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      int         k;
      int         n;
      logic [3:0] t;
      logic [3:0] o;
      k = $urandom_range(0, 5);
      case (k)
        0: begin t = 4'd0; o = 4'd0; end
        1: begin t = 4'd0; o = 4'd1; end
        2: begin t = 4'd10; o = 4'd10; end
        3: begin t = 4'($urandom_range(0, 15)); o = 4'($urandom_range(0, 15)); end
        4: begin t = 4'd2; o = 4'd5; end
        default: begin t = 4'd1; o = 4'd0; end
      endcase
      n = $urandom_range(1, 20);
      for (int j = 0; j < n; j++) cyc(t, o, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 29) == 0) do_reset();
    end

    repeat (3) @(negedge clk);
    #1;
    check("drain", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
# countdown_display

Consumer side of the two-digit BCD countdown bus. Samples the ones/tens digit pair with a stability filter and decodes it to two active-low seven-segment displays. Detects expiry (a running count reaching 00), then drives a blinking display and an alarm output for a fixed number of blink periods or until acknowledged. Sits between the countdown block and the board HEX displays and buzzer.

## Interface
- TICK_DIV, 25000000: clock cycles per blink half-period (0.5 s at 50 MHz); must be ≥2.
- ALARM_BLINKS, 6: full blink periods (on and off) before the alarm self-clears; must be ≥1.
- clock  in  1  system clock; all registers use the rising edge.
- reset  in  1  asynchronous, active-low reset.
- digit1  in  4  ones digit; 0-9 valid, 10 = blank, 11-15 invalid.
- digit2  in  4  tens digit; same coding as digit1.
- ack  in  1  alarm acknowledge, level from a pushbutton, asynchronous.
- hex0  out  7  ones display, active-low, bit0=a … bit6=g.
- hex1  out  7  tens display, same coding.
- alarm  out  1  high while in ALARM.
- expired  out  1  high in ALARM and DONE.

## Operation
- Input filter: s1 <= {digit2,digit1}; s2 <= s1; held <= s2 only when s1==s2. A value must be stable for 2 consecutive samples to reach held.
- Decode from held, per digit, gfedcba active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 10=1111111 (blank), 11-15=0111111 (dash). Decoded value registered into hex0/hex1.
- Classes of held: BLANK = either digit ≥10; ZERO = 0/0; RUN = valid and nonzero.
- FSM states: IDLE, COUNTING, ALARM, DONE.
  - IDLE: RUN → COUNTING; ZERO → DONE, no alarm.
  - COUNTING: ZERO → ALARM; BLANK → IDLE.
  - ALARM: RUN → COUNTING; BLANK → IDLE; otherwise an ack rising edge → DONE; otherwise after 2·ALARM_BLINKS ticks → DONE.
  - DONE: RUN → COUNTING; BLANK → IDLE.
  - Priority in ALARM: held class > ack > tick expiry.
- Prescaler runs only in ALARM. It is cleared on entry to ALARM and counts 0..TICK_DIV-1. The tick fires on the terminal count, and the counter wraps to 0.
- Blink phase: 0 (visible) on entry to ALARM; toggles on each tick. Phase 1 forces hex0=hex1=1111111. Outside ALARM the phase is always 0.
- Blink counter: cleared on entry to ALARM; increments per tick; reaching 2·ALARM_BLINKS exits to DONE on that same tick edge.
- ack: 2-flop synchronizer plus a previous-value register. A rising edge is counted only in ALARM; ack held high while entering ALARM does not count.
- Counter widths: $clog2(TICK_DIV) and $clog2(2·ALARM_BLINKS+1). No overflow is possible.

## Timing
- Reset (asynchronous assert, synchronous release on the next edge):
  - state=IDLE
  - s1=s2=held={10,10}
  - hex0=hex1=1111111
  - alarm=0, expired=0
  - prescaler, blink counter and phase = 0
  - ack synchronizer = 0
- Digit latency: inputs stable before edge 1 → s1 at edge 1, s2 at edge 2, held at edge 3, hex and state update at edge 4.
- alarm and expired are registered and change on the same edge as state. Expiry is visible at edge 4 after 00 is presented.
- In ALARM, the first blank phase starts TICK_DIV cycles after entry. Total alarm duration is 2·ALARM_BLINKS·TICK_DIV cycles.
- ack: a rising edge before edge 1 → state DONE at edge 3; alarm falls and display is steady from that edge.
- Reset mid-ALARM clears alarm immediately. When 00 is then re-presented, the FSM goes IDLE→DONE with no alarm.
- A single-cycle glitch on the digit inputs never reaches held.

## Test plan
- Reset: assert reset=0 → hex0=hex1=1111111, alarm=0, expired=0, with no clock edge needed.
- Decode: digit2=2, digit1=5 stable → at edge 4 hex1=0100100, hex0=0010010, state COUNTING; sweep 0-9, 10, 12 on each digit and check table values.
- Expiry (TICK_DIV=4, ALARM_BLINKS=2): 0/1 then 0/0 →
  - at edge 4: alarm=1, expired=1, hex=1000000/1000000
  - blank for cycles 4-7 and 12-15 after entry
  - alarm=0 at cycle 16, expired stays 1, display steady 00
- ack: pulse ack high 1 cycle at ALARM cycle 5 → DONE 3 edges later, alarm=0, expired=1, hex visible. ack held high across ALARM entry → no early exit.
- Glitch and reload: in COUNTING, change digit1 for one cycle → hex unchanged. In ALARM, present 3/0 stably → COUNTING with alarm=0 and expired=0. Present 10/10 → IDLE with blank displays.
- Reset mid-ALARM, then 0/0 → state DONE, alarm never asserts, expired=1.
